// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the two-master Wishbone arbiter.
//   - Wishbone cycle-type (CTI) codes
//   - arbiter state encoding
//   - width of the bus watchdog counter
package wb_arb_pkg;

    // Wishbone registered-feedback cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Watchdog counter width; covers the full legal timeout range 2..65535
    localparam int WDOG_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: bus stall watchdog.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr          : clear the counter this cycle
//   run          : a strobe is outstanding this cycle
//   expire       : one-cycle pulse when run has been held for 'timeout'
//                  consecutive uncleared cycles
// The counter wraps to zero on expiry, so a master that keeps its strobe
// up after the forced error gets another full timeout window.
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int timeout = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(timeout - 1);

    logic [WDOG_W-1:0] count;

    // Expiry is combinational so the error lands in the same cycle the
    // count reaches its limit (the timeout-th strobe cycle).
    assign expire = run && (count == LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master, one-slave Wishbone arbiter.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   m0_* / m1_*            : master ports (adr, dat, sel, we, cyc, stb, cti,
//                            lock in; dat, ack, err, rty out)
//   s_*                    : slave port (muxed master signals out, gated
//                            cyc/stb out; dat, ack, err, rty in)
//   dbg_state              : current arbiter state, for observation
// Grant is registered and round-robin at cycle boundaries; an owner keeps
// the bus while its cyc or lock is high, so bursts and locked sequences are
// never preempted. Slave terminations and read data pass combinationally.
//
// Handshake: a beat completes in any cycle where the owner's stb is high on
// the slave port and the slave raises exactly one of ack/err/rty; the
// arbiter adds no wait state to that path, and terminations go only to the
// current owner.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int timeout   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [adr_width-1:0]   m0_adr_i,
    input  logic [dat_width-1:0]   m0_dat_i,
    output logic [dat_width-1:0]   m0_dat_o,
    input  logic [dat_width/8-1:0] m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic [2:0]             m0_cti_i,
    input  logic                   m0_lock_i,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,
    output logic                   m0_rty_o,

    input  logic [adr_width-1:0]   m1_adr_i,
    input  logic [dat_width-1:0]   m1_dat_i,
    output logic [dat_width-1:0]   m1_dat_o,
    input  logic [dat_width/8-1:0] m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic [2:0]             m1_cti_i,
    input  logic                   m1_lock_i,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,
    output logic                   m1_rty_o,

    output logic [adr_width-1:0]   s_adr_o,
    output logic [dat_width-1:0]   s_dat_o,
    output logic [dat_width/8-1:0] s_sel_o,
    output logic                   s_we_o,
    output logic [2:0]             s_cti_o,
    output logic                   s_lock_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic [dat_width-1:0]   s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_rty_i,

    output arb_state_t             dbg_state
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last;        // master granted most recently (tie-breaker)
    logic       own0;
    logic       own1;
    logic       owner_cyc;
    logic       owner_stb;
    logic       expire;
    logic       wd_clr;
    logic       s_term;

    assign own0      = (state == GNT0);
    assign own1      = (state == GNT1);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Next-state decision
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                // lock bridges the one-cycle cyc gap between locked cycles
                if (!m0_cyc_i && !m0_lock_i) begin
                    state_next = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i && !m1_lock_i) begin
                    state_next = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            if (state != GNT0 && state_next == GNT0) begin
                last <= 1'b0;
            end else if (state != GNT1 && state_next == GNT1) begin
                last <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Master -> slave muxes (m0 selected whenever m1 is not the owner)
    // ------------------------------------------------------------------
    assign s_adr_o  = own1 ? m1_adr_i  : m0_adr_i;
    assign s_dat_o  = own1 ? m1_dat_i  : m0_dat_i;
    assign s_sel_o  = own1 ? m1_sel_i  : m0_sel_i;
    assign s_we_o   = own1 ? m1_we_i   : m0_we_i;
    assign s_cti_o  = own1 ? m1_cti_i  : m0_cti_i;
    assign s_lock_o = own1 ? m1_lock_i : m0_lock_i;

    assign owner_cyc = (own0 && m0_cyc_i) || (own1 && m1_cyc_i);
    assign owner_stb = (own0 && m0_stb_i) || (own1 && m1_stb_i);

    // The watchdog expiry pulls cyc/stb down for that cycle so the slave
    // sees the stalled access abandoned.
    assign s_cyc_o = owner_cyc && !expire;
    assign s_stb_o = owner_stb && !expire;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    assign s_term = s_ack_i || s_err_i || s_rty_i;
    // Run on the owner's raw strobe: using the gated s_stb_o would make
    // the expiry cycle clear itself.
    assign wd_clr = (state_next != state) || s_term || !owner_stb;

    wb_watchdog #(
        .timeout(timeout)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (wd_clr),
        .run   (owner_stb),
        .expire(expire)
    );

    // ------------------------------------------------------------------
    // Slave -> master routing. Terminations reach the owner only; during
    // a reset cycle they are suppressed so an aborted transfer never
    // completes. An expiry overrides any slave ack/rty in the same cycle.
    // ------------------------------------------------------------------
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = !rst_i && own0 && s_ack_i && !expire;
    assign m0_rty_o = !rst_i && own0 && s_rty_i && !expire;
    assign m0_err_o = !rst_i && own0 && (s_err_i || expire);

    assign m1_ack_o = !rst_i && own1 && s_ack_i && !expire;
    assign m1_rty_o = !rst_i && own1 && s_rty_i && !expire;
    assign m1_err_o = !rst_i && own1 && (s_err_i || expire);

endmodule
